// File: rtl/mem_arbiter_pkg.sv
// Shared constants and state encoding for the fetch/data memory arbiter.
// Imported by the arbiter and its latency counter.
package mem_arbiter_pkg;

    localparam int WORD_SIZE = 16;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arbiter_latency_counter.sv
// Loadable down-counter timing one memory access.
// Stops at zero and flags it.
module latency_counter
    import mem_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (enable && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of one fixed-latency memory port.
// Data has priority; a starvation counter forces a fetch after two data grants.
module mem_arbiter #(
    parameter int WORD_SIZE = mem_arbiter_pkg::WORD_SIZE,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_ack,
    output logic [WORD_SIZE-1:0] if_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 busy
);

    import mem_arbiter_pkg::*;

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY - 1);

    state_t               state;
    state_t               next_state;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 we_q;
    logic                 gnt_d_q;
    logic [1:0]           starve_q;
    logic                 fetch_wins;
    logic                 accept;
    logic                 in_busy;
    logic                 zero;

    // Fetch only beats a pending data request once it has lost twice.
    assign fetch_wins = if_req && (!d_req || starve_q == 2'd2);
    assign in_busy    = (state == BUSY_I) || (state == BUSY_D);

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    accept     = 1'b1;
                    next_state = fetch_wins ? BUSY_I : BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (zero) begin
                    next_state = DONE;
                end
            end
            DONE: next_state = IDLE;
        endcase
    end

    latency_counter u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (LOAD_VAL),
        .enable   (in_busy),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            gnt_d_q  <= 1'b0;
            starve_q <= 2'd0;
        end else begin
            state <= next_state;
            if (accept) begin
                gnt_d_q <= !fetch_wins;
                addr_q  <= fetch_wins ? if_addr : d_addr;
                we_q    <= !fetch_wins && d_we;
                wdata_q <= fetch_wins ? '0 : d_wdata;
                if (fetch_wins) begin
                    starve_q <= 2'd0;
                end else if (if_req && starve_q != 2'd2) begin
                    starve_q <= starve_q + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (in_busy && zero) begin
            if (state == BUSY_I) begin
                if_rdata <= mem_rdata;
            end else if (!we_q) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign mem_read  = in_busy && !we_q;
    assign mem_write = in_busy && we_q;
    assign mem_addr  = in_busy ? addr_q : '0;
    assign mem_wdata = in_busy ? wdata_q : '0;
    assign if_ack    = (state == DONE) && !gnt_d_q;
    assign d_ack     = (state == DONE) && gnt_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, directed corners,
// latency sweep instances and a randomized run against a transaction model.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sw_rst_n;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, mem_read, mem_write, busy;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        if (a == 16'h0010) return 16'hBEEF;
        return {a[7:0], ~a[15:8]};
    endfunction

    assign mem_rdata = rom(mem_addr);

    mem_arbiter #(.WORD_SIZE(16), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_sweep
        localparam int SL = (k == 0) ? 1 : 15;
        logic        s_if_req, s_d_req, s_d_we, s_if_ack, s_d_ack;
        logic        s_rd, s_wr, s_busy, done;
        logic [15:0] s_if_addr, s_d_addr, s_d_wdata, s_if_rdata;
        logic [15:0] s_d_rdata, s_maddr, s_mwdata, s_mrdata;

        assign s_mrdata = rom(s_maddr);

        mem_arbiter #(.WORD_SIZE(16), .LATENCY(SL)) u_sw (
            .clk(clk), .reset_n(sw_rst_n),
            .if_req(s_if_req), .if_addr(s_if_addr),
            .if_ack(s_if_ack), .if_rdata(s_if_rdata),
            .d_req(s_d_req), .d_we(s_d_we), .d_addr(s_d_addr),
            .d_wdata(s_d_wdata), .d_ack(s_d_ack), .d_rdata(s_d_rdata),
            .mem_read(s_rd), .mem_write(s_wr),
            .mem_addr(s_maddr), .mem_wdata(s_mwdata),
            .mem_rdata(s_mrdata), .busy(s_busy)
        );

        initial begin
            int n_ack, n_busy, n_mem;
            string t;
            t = $sformatf("sweep L%0d", SL);
            done = 1'b0;
            s_if_req = 0; s_d_req = 0; s_d_we = 0;
            s_if_addr = 0; s_d_addr = 0; s_d_wdata = 0;
            for (int i = 0; i < 100 && !sw_rst_n; i++) @(posedge clk);
            @(posedge clk); #1;
            s_if_req = 1; s_if_addr = 16'h0010;
            @(posedge clk);
            n_ack = 0; n_busy = 0; n_mem = 0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (!s_busy) break;
                n_busy++;
                if (s_rd) n_mem++;
                if (s_if_ack && n_ack == 0) n_ack = c;
                if (s_if_ack) begin
                    @(posedge clk); #1;
                    s_if_req = 0;
                end
            end
            chk({t, " fetch ack edge"}, n_ack, SL + 1);
            chk({t, " fetch busy cycles"}, n_busy, SL + 1);
            chk({t, " fetch read cycles"}, n_mem, SL);
            chk({t, " if_rdata"}, s_if_rdata, 16'hBEEF);
            @(posedge clk); #1;
            s_d_req = 1; s_d_we = 1; s_d_addr = 16'h0040; s_d_wdata = 16'h1234;
            @(posedge clk);
            n_ack = 0; n_busy = 0; n_mem = 0;
            for (int c = 1; c <= 40; c++) begin
                @(negedge clk);
                if (!s_busy) break;
                n_busy++;
                if (s_wr) begin
                    n_mem++;
                    chk({t, " write data"}, s_mwdata, 16'h1234);
                end
                if (s_d_ack && n_ack == 0) n_ack = c;
                if (s_d_ack) begin
                    @(posedge clk); #1;
                    s_d_req = 0; s_d_we = 0;
                end
            end
            chk({t, " write ack edge"}, n_ack, SL + 1);
            chk({t, " write busy cycles"}, n_busy, SL + 1);
            chk({t, " write cycles"}, n_mem, SL);
            chk({t, " d_rdata kept"}, s_d_rdata, 16'h0000);
            done = 1'b1;
        end
    end

    typedef struct {
        logic        is_d;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    task automatic run_txn(input logic is_d, input logic we,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [15:0] exp_rd, input string t);
        if (is_d) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1; if_addr = addr;
        end
        @(posedge clk);
        for (int c = 0; c < LAT; c++) begin
            @(negedge clk);
            chk({t, " mem_read"}, mem_read, !we);
            chk({t, " mem_write"}, mem_write, we);
            chk({t, " mem_addr"}, mem_addr, addr);
            if (we) chk({t, " mem_wdata"}, mem_wdata, wdata);
            chk({t, " early ack"}, {if_ack, d_ack}, 2'b00);
        end
        @(negedge clk);
        chk({t, " acks"}, {if_ack, d_ack}, {!is_d, is_d});
        chk({t, " done mem idle"}, {mem_read, mem_write}, 2'b00);
        chk({t, " rdata"}, is_d ? d_rdata : if_rdata, exp_rd);
        @(posedge clk); #1;
        if_req = 0; d_req = 0; d_we = 0;
        @(negedge clk);
        chk({t, " back idle"}, {busy, if_ack, d_ack}, 3'b000);
        @(posedge clk); #1;
    endtask

    task automatic run_table();
        vec_t v[7];
        v[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        v[1] = '{1'b1, 1'b1, 16'h0040, 16'h1234, 16'h0000};
        v[2] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'h34ED};
        v[3] = '{1'b1, 1'b1, 16'h0040, 16'hFFFF, 16'h34ED};
        v[4] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'hFFFF};
        v[5] = '{1'b0, 1'b0, 16'hA500, 16'h0000, 16'h005A};
        v[6] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'hFF00};
        foreach (v[i])
            run_txn(v[i].is_d, v[i].we, v[i].addr, v[i].wdata, v[i].exp_rd,
                    $sformatf("vec%0d", i));
        chk("if_rdata held", if_rdata, 16'h005A);
    endtask

    task automatic run_simul();
        int t_d, t_i;
        logic da, ia;
        t_d = -1; t_i = -1;
        if_req = 1; if_addr = 16'h0100;
        d_req = 1; d_we = 0; d_addr = 16'h0200;
        for (int c = 0; c < 30 && t_i < 0; c++) begin
            @(negedge clk);
            da = d_ack; ia = if_ack;
            if (da && ia) chk("simul both acks", 1, 0);
            if (da) t_d = c;
            if (ia) t_i = c;
            @(posedge clk); #1;
            if (da) d_req = 0;
            if (ia) if_req = 0;
        end
        if_req = 0; d_req = 0;
        chk("simul data first", (t_d >= 0 && t_d < t_i), 1);
        chk("simul spacing", t_i - t_d, LAT + 2);
        chk("simul d_rdata", d_rdata, rom(16'h0200));
        chk("simul if_rdata", if_rdata, rom(16'h0100));
    endtask

    task automatic run_starve();
        string order;
        order = "";
        if_req = 1; if_addr = 16'h0300;
        d_req = 1; d_we = 0; d_addr = 16'h0400;
        for (int c = 0; c < 80 && order.len() < 6; c++) begin
            @(negedge clk);
            if (d_ack) order = {order, "D"};
            if (if_ack) order = {order, "I"};
        end
        @(posedge clk); #1;
        if_req = 0; d_req = 0;
        checks++;
        if (order != "DDIDDI") begin
            errors++;
            $display("FAIL starve order: got %s expected DDIDDI", order);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_reset_mid();
        int n_ack;
        n_ack = 0;
        d_req = 1; d_we = 0; d_addr = 16'h0500;
        @(posedge clk); #1;
        chk("rst pre busy", {busy, mem_read}, 2'b11);
        #2 reset_n = 0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst mem ctl", {mem_read, mem_write}, 2'b00);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst acks", {if_ack, d_ack}, 2'b00);
        chk("rst d_rdata", d_rdata, 0);
        chk("rst if_rdata", if_rdata, 0);
        d_req = 0;
        repeat (3) begin
            @(negedge clk);
            if (if_ack || d_ack) n_ack++;
        end
        @(posedge clk); #3 reset_n = 1;
        repeat (4) begin
            @(negedge clk);
            if (if_ack || d_ack) n_ack++;
        end
        chk("rst no ack", n_ack, 0);
        @(posedge clk); #1;
        run_txn(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, "post-rst fetch");
    endtask

    task automatic run_random(input int n);
        int          bl, stv;
        logic        cur_d, cur_we, fw, e_mem, drop_i, drop_d;
        logic [15:0] cur_addr, cur_wdata, exp_i, exp_d;
        bl = 0; stv = 0; cur_d = 0; cur_we = 0;
        cur_addr = 0; cur_wdata = 0; exp_i = 0; exp_d = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            e_mem = (bl >= 2);
            chk("rnd busy", busy, bl > 0);
            chk("rnd mem_read", mem_read, e_mem && !cur_we);
            chk("rnd mem_write", mem_write, e_mem && cur_we);
            if (e_mem) chk("rnd mem_addr", mem_addr, cur_addr);
            if (e_mem && cur_we) chk("rnd mem_wdata", mem_wdata, cur_wdata);
            chk("rnd if_ack", if_ack, bl == 1 && !cur_d);
            chk("rnd d_ack", d_ack, bl == 1 && cur_d);
            chk("rnd if_rdata", if_rdata, exp_i);
            chk("rnd d_rdata", d_rdata, exp_d);
            drop_i = (bl == 1 && !cur_d);
            drop_d = (bl == 1 && cur_d);
            // Occupancy model: L memory cycles then one ack cycle.
            if (bl > 0) begin
                bl--;
                if (bl == 1 && !cur_we) begin
                    if (cur_d) exp_d = rom(cur_addr);
                    else       exp_i = rom(cur_addr);
                end
            end else if (if_req || d_req) begin
                fw        = if_req && (!d_req || stv == 2);
                cur_d     = !fw;
                cur_addr  = fw ? if_addr : d_addr;
                cur_we    = !fw && d_we;
                cur_wdata = d_wdata;
                if (fw) stv = 0;
                else if (if_req && stv < 2) stv++;
                bl = LAT + 1;
            end
            @(posedge clk); #1;
            if (drop_i) if_req = 0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = 16'($urandom);
            end
            if (drop_d) begin
                d_req = 0; d_we = 0;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom_range(0, 1));
                d_addr = 16'($urandom); d_wdata = 16'($urandom);
            end
        end
        if_req = 0; d_req = 0; d_we = 0;
        repeat (LAT + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 0; sw_rst_n = 0;
        if_req = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset acks", {if_ack, d_ack}, 2'b00);
        chk("reset mem ctl", {mem_read, mem_write}, 2'b00);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset rdata", {if_rdata, d_rdata}, 0);
        @(posedge clk); #1;
        reset_n = 1; sw_rst_n = 1;
        @(posedge clk); #1;
        run_table();
        run_simul();
        run_starve();
        run_reset_mid();
        reset_n = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        @(posedge clk); #1;
        run_random(800);
        for (int i = 0; i < 2000 && !(g_sweep[0].done && g_sweep[1].done); i++)
            @(posedge clk);
        chk("sweep finished", {g_sweep[0].done, g_sweep[1].done}, 2'b11);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set the data/address width.
REQ-002 Parameter LATENCY, default 2, SHALL set memory access cycles (legal range 1..15).
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port reset_n  input  1  SHALL be the reset: asynchronous and active-low.
REQ-005 Ports if_req in 1, if_addr in WORD_SIZE SHALL carry the fetch request (read-only).
REQ-006 Ports if_ack out 1, if_rdata out WORD_SIZE SHALL carry the fetch completion and its data.
REQ-007 Ports d_req in 1, d_we in 1, d_addr in WORD_SIZE, d_wdata in WORD_SIZE SHALL carry the data-port request.
REQ-008 Ports d_ack out 1, d_rdata out WORD_SIZE SHALL carry the data-port completion and its data.
REQ-009 Ports mem_read out 1, mem_write out 1, mem_addr out WORD_SIZE, mem_wdata out WORD_SIZE, mem_rdata in WORD_SIZE SHALL form the single shared memory port.
REQ-010 Port busy  out 1  SHALL be high in every state except IDLE.

Function
REQ-011 The FSM SHALL have exactly four states: IDLE, BUSY_I, BUSY_D, DONE.
REQ-012 In IDLE, the arbiter SHALL accept a request at a clock edge where if_req or d_req is high.
- Winner selection follows REQ-013.
- On acceptance it SHALL latch the winner's addr, we and wdata.
- It SHALL load cnt = LATENCY-1.
- It SHALL enter BUSY_I or BUSY_D.
REQ-013 Priority SHALL be data over fetch, except that fetch wins when starve_cnt == 2.
REQ-014 starve_cnt (2 bits) SHALL increment, saturating at 2, on each data grant made while if_req is high, and SHALL clear on each fetch grant.
REQ-015 In BUSY_x, mem_addr and mem_wdata SHALL drive the latched values.
- mem_read SHALL equal the inverse of latched we (always 1 for fetch).
- mem_write SHALL equal latched we.
- Both SHALL be held constant for all LATENCY cycles.
REQ-016 In BUSY_x, cnt SHALL decrement each cycle.
- At the edge where cnt == 0, mem_rdata SHALL be captured into the granted port's rdata register.
- The FSM SHALL then enter DONE.
REQ-017 In DONE, the granted port's ack SHALL be high for exactly that one cycle, and mem_read and mem_write SHALL be 0.
- The FSM SHALL then enter IDLE unconditionally.
- Resulting latency: ack is high in the cycle after edge E0+LATENCY, where E0 is the acceptance edge.
REQ-018 if_ack and d_ack SHALL never be high in the same cycle.
REQ-019 if_rdata and d_rdata SHALL hold their last captured value until the next read completion on that port.
- A write SHALL leave d_rdata unchanged.
REQ-020 Requester behaviour SHALL be as follows.
- Requesters hold req and operands stable until ack, and drop req at the edge ending the ack cycle.
- Changes to operands after acceptance SHALL be ignored.
- A req deasserted mid-access SHALL NOT abort it; the access completes and ack still pulses.
REQ-021 When both requests arrive at the same edge, exactly one grant SHALL occur per REQ-013.
- The loser's request remains pending for the next IDLE.
REQ-022 A request is never dropped, and minimum request spacing SHALL be LATENCY+2 cycles per port.

Reset
REQ-023 While reset_n is low, the following SHALL be forced immediately, independent of clk:
- state = IDLE, cnt = 0, starve_cnt = 0;
- all latched operands = 0;
- if_rdata = 0, d_rdata = 0;
- all outputs = 0.
REQ-024 Reset asserted mid-access SHALL abandon the access with no ack; after deassertion, the first edge in IDLE SHALL arbitrate normally.

Structure
REQ-025 State encodings (IDLE=0, BUSY_I=1, BUSY_D=2, DONE=3) and WORD_SIZE SHALL live in the shared opcodes/constants include; LATENCY SHALL remain a module parameter.
REQ-026 The latency down-counter SHALL be a sub-module named latency_counter (load, enable, zero flag); all other logic stays in mem_arbiter.

Verification
REQ-027 The bench SHALL cover the following directed scenarios (LATENCY=2 unless noted).
- Fetch read: if_req=1, if_addr=0x0010, mem model returns 0xBEEF. Expect mem_read=1 and mem_addr=0x0010 for 2 cycles, then if_ack=1 for 1 cycle with if_rdata=0xBEEF.
- Data write: d_req=1, d_we=1, d_addr=0x0040, d_wdata=0x1234. Expect mem_write=1 for 2 cycles with the correct addr/wdata; d_ack pulses once; d_rdata unchanged.
- Simultaneous request: if_req and d_req rise at the same edge. Expect the data access first (d_ack), then the fetch; if_ack follows d_ack by exactly LATENCY+2 cycles.
- Starvation guard: if_req held high, d_req re-asserted after every d_ack. Expect grant order D, D, I, D, D, I.
- Reset mid-access: reset_n=0 during BUSY_D cycle 1. Expect all outputs 0 immediately, no d_ack; after release, a new if_req completes normally.
- Latency sweep: LATENCY=1 and LATENCY=15. Expect ack exactly LATENCY+1 edges after acceptance; busy high for LATENCY+1 cycles.
